// File: rtl/data_mem_ctrl_if.sv
// Core-side request/response bus for data_mem_ctrl.
//   addr_i          : byte address of the request
//   write_data_i    : store data (byte stores use bits [7:0])
//   valid_i         : request valid
//   wen_i           : 1 = store, 0 = load
//   byte_not_word_i : 1 = byte access, 0 = word access
//   yumi_i          : core consumes the current response
//   read_data_o     : load response data
//   valid_o         : response valid
//   yumi_o          : request accepted this cycle
//   err_o           : sticky access-error flag
interface data_mem_ctrl_if;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic        valid_i;
    logic        wen_i;
    logic        byte_not_word_i;
    logic        yumi_i;
    logic [31:0] read_data_o;
    logic        valid_o;
    logic        yumi_o;
    logic        err_o;

    modport master (
        output addr_i, write_data_i, valid_i, wen_i, byte_not_word_i, yumi_i,
        input  read_data_o, valid_o, yumi_o, err_o
    );

    modport slave (
        input  addr_i, write_data_i, valid_i, wen_i, byte_not_word_i, yumi_i,
        output read_data_o, valid_o, yumi_o, err_o
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller with fixed response latency.
// A request is accepted in IDLE, the array is accessed at the acceptance
// edge, and the response is presented latency_p cycles later and held
// until the core consumes it with yumi_i.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : core request/response bus (slave side)
module data_mem_ctrl #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [2:0]                r_cnt;
    logic [2:0]                w_next_cnt;
    logic [31:0]               r_resp;
    logic                      r_err;
    logic [31:0]               r_mem [2**addr_width_p];

    logic                      w_accept;
    logic                      w_oor;
    logic                      w_misaligned;
    logic [addr_width_p-1:0]   w_idx;
    logic [1:0]                w_lane;
    logic [3:0]                w_be;
    logic [31:0]               w_wdata;
    logic [31:0]               w_rword;
    logic [7:0]                w_rbyte;

    // Acceptance is blocked while reset is held so no store can slip in.
    assign w_accept     = reset && (r_state == IDLE) && bus.valid_i;
    assign w_idx        = bus.addr_i[addr_width_p+1:2];
    assign w_lane       = bus.addr_i[1:0];
    assign w_oor        = |bus.addr_i[31:addr_width_p+2];
    // A misaligned word access still uses w_idx; the lane bits are ignored.
    assign w_misaligned = !bus.byte_not_word_i && (w_lane != 2'b00);

    // Byte stores replicate the byte to every lane and enable only one.
    assign w_be    = bus.byte_not_word_i ? (4'b0001 << w_lane) : 4'b1111;
    assign w_wdata = bus.byte_not_word_i ? {4{bus.write_data_i[7:0]}} : bus.write_data_i;
    assign w_rword = r_mem[w_idx];
    assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];

    // NOTE: next-state logic gets defaults first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_cnt   = 3'(latency_p - 1);
                    w_next_state = (latency_p == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt != 3'd0) begin
                    w_next_cnt = r_cnt - 3'd1;
                end
                // The counter reaches zero on this edge.
                if (r_cnt <= 3'd1) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (bus.yumi_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Response register and sticky error, captured at acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp <= 32'd0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_err <= r_err | w_oor | w_misaligned;
            if (bus.wen_i || w_oor) begin
                r_resp <= 32'd0;
            end else if (bus.byte_not_word_i) begin
                r_resp <= {24'd0, w_rbyte};
            end else begin
                r_resp <= w_rword;
            end
        end
    end

    // NOTE: the array has no reset; stored data must survive a reset and a
    // resettable memory could not map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_accept && bus.wen_i && !w_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.yumi_o      = w_accept;
    assign bus.valid_o     = reset && (r_state == RESP);
    assign bus.read_data_o = reset ? r_resp : 32'd0;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a latency-2 instance (bus0) runs
// directed scenarios and random traffic against a word-array model; a
// latency-1 instance (bus1) covers the single-cycle path.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic reset;

    data_mem_ctrl_if bus0 ();
    data_mem_ctrl_if bus1 ();

    data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: sparse word array plus sticky error bit.
    logic [31:0] m_mem [int unsigned];
    bit          m_err = 1'b0;

    function automatic logic [31:0] model_op(input bit wen, input bit bnw,
                                             input logic [31:0] a, input logic [31:0] wd);
        int unsigned idx  = a / 4;
        int unsigned lane = a % 4;
        logic [31:0] mask = 32'hFF << (8 * lane);
        if (a >= 32'h1000) begin
            m_err = 1'b1;
            return 32'd0;
        end
        if (!bnw && lane != 0) m_err = 1'b1;
        if (wen) begin
            if (bnw) m_mem[idx] = (m_mem[idx] & ~mask) | ({24'd0, wd[7:0]} << (8 * lane));
            else     m_mem[idx] = wd;
            return 32'd0;
        end
        if (bnw) return (m_mem[idx] >> (8 * lane)) & 32'hFF;
        return m_mem[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input bit v, input bit wen, input bit bnw,
                           input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.valid_i = v; bus0.wen_i = wen; bus0.byte_not_word_i = bnw;
            bus0.addr_i = a;  bus0.write_data_i = wd;
        end else begin
            bus1.valid_i = v; bus1.wen_i = wen; bus1.byte_not_word_i = bnw;
            bus1.addr_i = a;  bus1.write_data_i = wd;
        end
    endtask

    task automatic set_yumi(input int sel, input bit y);
        if (sel == 0) bus0.yumi_i = y;
        else          bus1.yumi_i = y;
    endtask

    function automatic logic get_yumi(input int sel);
        return (sel == 0) ? bus0.yumi_o : bus1.yumi_o;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? bus0.valid_o : bus1.valid_o;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus0.read_data_o : bus1.read_data_o;
    endfunction

    // Entered ~1ns after an edge with the request driven; leaves ~1ns after
    // the acceptance edge with valid_i dropped.
    task automatic wait_accept(input int sel);
        int t = 0;
        #1;
        while (get_yumi(sel) !== 1'b1 && t < 20) begin
            @(posedge clk); #2;
            t++;
        end
        check("accept", 32'(get_yumi(sel)), 32'd1);
        @(posedge clk); #1;
        set_req(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Counts cycles from acceptance to the first valid_o.
    task automatic wait_valid(input int sel);
        int k = 1;
        while (get_valid(sel) !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), (sel == 0) ? 32'd2 : 32'd1);
    endtask

    task automatic finish_resp(input int sel, input int hold, output logic [31:0] rd);
        wait_valid(sel);
        rd = get_rdata(sel);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(get_valid(sel)), 32'd1);
            check("hold_data", get_rdata(sel), rd);
        end
        set_yumi(sel, 1'b1);
        @(posedge clk); #1;
        set_yumi(sel, 1'b0);
        check("retired", 32'(get_valid(sel)), 32'd0);
    endtask

    task automatic txn(input int sel, input bit wen, input bit bnw, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, output logic [31:0] rd);
        set_req(sel, 1'b1, wen, bnw, a, wd);
        wait_accept(sel);
        finish_resp(sel, hold, rd);
    endtask

    // Model-checked transaction on the latency-2 instance.
    task automatic op(input string tag, input bit wen, input bit bnw, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, output logic [31:0] rd);
        logic [31:0] exp;
        exp = model_op(wen, bnw, a, wd);
        txn(0, wen, bnw, a, wd, hold, rd);
        check(tag, rd, exp);
        check({tag, "_err"}, 32'(bus0.err_o), 32'(m_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] v;

        // Reset with a request pending: nothing may be accepted or shown.
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_yumi(0, 1'b0);
        set_yumi(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_yumi", 32'(bus0.yumi_o), 32'd0);
        check("rst_valid", 32'(bus0.valid_o), 32'd0);
        check("rst_rdata", bus0.read_data_o, 32'd0);
        check("rst_err", 32'(bus0.err_o), 32'd0);
        set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_valid", 32'(bus0.valid_o), 32'd0);

        // Word store then load.
        op("w_store", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
        op("w_load", 1'b0, 1'b0, 32'h10, 32'd0, 1, rd);
        check("w_load_const", rd, 32'hDEADBEEF);

        // Byte lanes.
        op("b_wstore", 1'b1, 1'b0, 32'h20, 32'h11223344, 0, rd);
        op("b_store", 1'b1, 1'b1, 32'h22, 32'h000000AA, 0, rd);
        op("b_wload", 1'b0, 1'b0, 32'h20, 32'd0, 0, rd);
        check("b_wload_const", rd, 32'h11AA3344);
        op("b_load", 1'b0, 1'b1, 32'h23, 32'd0, 0, rd);
        check("b_load_const", rd, 32'h00000011);

        // Backpressure: response held 5 cycles with a new request waiting.
        exp = model_op(1'b0, 1'b0, 32'h20, 32'd0);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
        wait_accept(0);
        wait_valid(0);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        #1;
        repeat (5) begin
            check("bp_valid", 32'(bus0.valid_o), 32'd1);
            check("bp_data", bus0.read_data_o, exp);
            check("bp_yumi", 32'(bus0.yumi_o), 32'd0);
            @(posedge clk); #2;
        end
        set_yumi(0, 1'b1);
        #1;
        check("retire_cycle_yumi", 32'(bus0.yumi_o), 32'd0);
        @(posedge clk); #1;
        set_yumi(0, 1'b0);
        check("bp_idle_valid", 32'(bus0.valid_o), 32'd0);
        exp = model_op(1'b0, 1'b0, 32'h10, 32'd0);
        wait_accept(0);
        finish_resp(0, 0, rd);
        check("bp_next_data", rd, exp);

        // Errors: out-of-range load, misaligned word store.
        op("oor_load", 1'b0, 1'b0, 32'h00001000, 32'd0, 0, rd);
        check("oor_rdata", rd, 32'd0);
        check("oor_err", 32'(bus0.err_o), 32'd1);
        op("mis_store", 1'b1, 1'b0, 32'h00000005, 32'hCAFEF00D, 0, rd);
        op("mis_readback", 1'b0, 1'b0, 32'h00000004, 32'd0, 0, rd);
        check("mis_readback_const", rd, 32'hCAFEF00D);
        check("err_sticky", 32'(bus0.err_o), 32'd1);

        // Reset while WAIT after a store: response dropped, store persists.
        v = 32'h5A5A0330;
        exp = model_op(1'b1, 1'b0, 32'h30, v);
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h30, v);
        wait_accept(0);
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        repeat (2) begin
            #1;
            check("midrst_valid", 32'(bus0.valid_o), 32'd0);
            check("midrst_yumi", 32'(bus0.yumi_o), 32'd0);
            check("midrst_rdata", bus0.read_data_o, 32'd0);
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        m_err = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("postrst_valid", 32'(bus0.valid_o), 32'd0);
        end
        check("postrst_err", 32'(bus0.err_o), 32'd0);
        op("persist", 1'b0, 1'b0, 32'h30, 32'd0, 0, rd);
        check("persist_const", rd, v);

        // Random traffic over a preinitialised region plus error cases.
        for (int i = 0; i < 16; i++) begin
            op("init", 1'b1, 1'b0, 32'h100 + 32'(4 * i), $urandom, 0, rd);
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit wen;
            bit bnw;
            wen = 1'($urandom_range(0, 1));
            bnw = 1'($urandom_range(0, 1));
            a   = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000 | ($urandom & 32'hFFFF_0000);
            op("rand", wen, bnw, a, $urandom, $urandom_range(0, 3), rd);
        end

        // Latency-1 instance.
        txn(1, 1'b1, 1'b0, 32'h40, 32'h0BADCAFE, 0, rd);
        check("lat1_store", rd, 32'd0);
        txn(1, 1'b0, 1'b0, 32'h40, 32'd0, 1, rd);
        check("lat1_load", rd, 32'h0BADCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
